// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - state encoding, board timing defaults and counter sizing shared by the clock design
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEAT     = 2'd2
  } rep_state_t;

  // Defaults assume the 100 MHz board clock.
  localparam int DEF_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 20_000_000;
  localparam int DEF_TICK_CYCLES          = 100_000_000;

  // Bits for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer and stability counter producing a debounced button level
module button_debouncer import clock_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic level_rise,
  output logic level_fall
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic            toggle;

  // rise/fall flag the edge on which btn_level is about to change, so the
  // repeat FSM can register its press pulse on that same edge.
  assign toggle     = (sync2 != btn_level) && (db_cnt == DB_LAST);
  assign level_rise = toggle && !btn_level;
  assign level_fall = toggle && btn_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == btn_level) begin
        db_cnt <= '0;
      end else if (toggle) begin
        btn_level <= ~btn_level;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/increment_pulser.sv
// rtl/increment_pulser.sv - 1 Hz tick divider and debounced set-button pulse with hold-to-auto-repeat
module increment_pulser import clock_pkg::*; #(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int TICK_CYCLES          = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic run_en,
  output logic tick_pulse,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RC_W = cnt_width(REP_MAX);
  localparam int TC_W = cnt_width(TICK_CYCLES);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [TC_W-1:0] TICK_LAST   = TC_W'(TICK_CYCLES - 1);

  rep_state_t      state;
  rep_state_t      state_next;
  logic [RC_W-1:0] rep_cnt;
  logic [RC_W-1:0] rep_cnt_next;
  logic            pulse_next;
  logic            level_rise;
  logic            level_fall;
  logic [TC_W-1:0] tick_cnt;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .level_rise(level_rise),
    .level_fall(level_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      rep_cnt   <= rep_cnt_next;
      btn_pulse <= pulse_next;
    end
  end

  // A release wins over everything, including a repeat due on the same edge.
  always_comb begin
    state_next = state;
    if (level_fall) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (level_rise) state_next = HOLD_DELAY;
        HOLD_DELAY: if (rep_cnt == DELAY_LAST) state_next = REPEAT;
        REPEAT:     state_next = REPEAT;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_next   = 1'b0;
    rep_cnt_next = '0;
    if (!level_fall) begin
      case (state)
        IDLE: pulse_next = level_rise;
        HOLD_DELAY: begin
          if (rep_cnt == DELAY_LAST) pulse_next = 1'b1;
          else rep_cnt_next = rep_cnt + RC_W'(1);
        end
        REPEAT: begin
          if (rep_cnt == PERIOD_LAST) pulse_next = 1'b1;
          else rep_cnt_next = rep_cnt + RC_W'(1);
        end
        default: pulse_next = 1'b0;
      endcase
    end
  end

  // Holding the count at zero while disabled makes re-enable start a full period.
  always_ff @(posedge clk) begin
    if (reset || !run_en) begin
      tick_cnt   <= '0;
      tick_pulse <= 1'b0;
    end else begin
      tick_pulse <= (tick_cnt == TICK_LAST);
      tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TC_W'(1);
    end
  end

endmodule

// File: tb/tb_increment_pulser.sv
// tb/tb_increment_pulser.sv - directed and randomized bench checked against a behavioural timing model
module tb_increment_pulser;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic run_en;
  logic tick_pulse;
  logic btn_pulse;
  logic btn_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  // Model state: raw delay line, window of last D seen levels, press edge, run start edge.
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;
  logic m_lvl = 1'b0;
  logic m_win[$];
  int   m_press = 0;
  int   m_run_start = -1;
  logic exp_btn = 1'b0;
  logic exp_tick = 1'b0;

  int   t0 = 0;
  int   pulse_q[$];
  int   tick_q[$];
  int   fall_rel = -1;
  int   rise_cnt = 0;
  logic prev_lvl = 1'b0;

  increment_pulser #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP),
    .TICK_CYCLES         (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .run_en    (run_en),
    .tick_pulse(tick_pulse),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n_edge, got, exp);
    end
  endtask

  task automatic check_q(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  // Level flips once the last D values reaching the debouncer all disagree with it;
  // pulses land on the press edge, press+RD, then every RP while the level stays high.
  task automatic model_edge();
    logic seen;
    bit   all_diff;
    bit   rose;
    n_edge++;
    if (reset) begin
      m_p1 = 1'b0;
      m_p2 = 1'b0;
      m_lvl = 1'b0;
      m_win.delete();
      m_run_start = -1;
      exp_btn = 1'b0;
      exp_tick = 1'b0;
    end else begin
      seen = m_p2;
      m_p2 = m_p1;
      m_p1 = btn_raw;
      m_win.push_back(seen);
      if (m_win.size() > D) void'(m_win.pop_front());
      all_diff = (m_win.size() == D);
      foreach (m_win[i]) if (m_win[i] == m_lvl) all_diff = 1'b0;
      rose = 1'b0;
      if (all_diff) begin
        m_lvl = ~m_lvl;
        if (m_lvl) begin
          rose = 1'b1;
          m_press = n_edge;
        end
      end
      exp_btn = m_lvl && (rose || ((n_edge - m_press >= RD) && ((n_edge - m_press - RD) % RP == 0)));
      if (run_en) begin
        if (m_run_start < 0) m_run_start = n_edge;
        exp_tick = ((n_edge - m_run_start + 1) % T == 0);
      end else begin
        m_run_start = -1;
        exp_tick = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check("btn_level", int'(btn_level), int'(m_lvl));
    check("btn_pulse", int'(btn_pulse), int'(exp_btn));
    check("tick_pulse", int'(tick_pulse), int'(exp_tick));
    if (btn_pulse) pulse_q.push_back(n_edge - t0);
    if (tick_pulse) tick_q.push_back(n_edge - t0);
    if (prev_lvl && !btn_level) fall_rel = n_edge - t0;
    if (!prev_lvl && btn_level) rise_cnt++;
    prev_lvl = btn_level;
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic start_test();
    t0 = n_edge;
    pulse_q.delete();
    tick_q.delete();
    fall_rel = -1;
    rise_cnt = 0;
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    run(k);
    reset = 1'b0;
  endtask

  initial begin
    int exp_q[$];
    int seg_len;

    // Reset held with button pressed and divider enabled.
    reset = 1'b1;
    btn_raw = 1'b1;
    run_en = 1'b1;
    run(3);
    reset = 1'b0;
    start_test();
    run(12);
    exp_q = '{6};
    check_q("t1_btn", pulse_q, exp_q);
    exp_q = '{8};
    check_q("t1_tick", tick_q, exp_q);

    // Clean 30-cycle press; the fall lands on a repeat boundary.
    btn_raw = 1'b0;
    run_en = 1'b0;
    do_reset(2);
    start_test();
    btn_raw = 1'b1;
    run(30);
    btn_raw = 1'b0;
    run(15);
    exp_q = '{6, 16, 21, 26, 31};
    check_q("t2_btn", pulse_q, exp_q);
    check("t2_fall_edge", fall_rel, 36);

    // Release whose fall coincides with the end of the hold delay.
    run(5);
    start_test();
    btn_raw = 1'b1;
    run(10);
    btn_raw = 1'b0;
    run(15);
    exp_q = '{6};
    check_q("t5_btn", pulse_q, exp_q);
    check("t5_fall_edge", fall_rel, 16);

    // Bounce with high widths 1, 2, 3.
    start_test();
    btn_raw = 1'b1; run(1);
    btn_raw = 1'b0; run(2);
    btn_raw = 1'b1; run(2);
    btn_raw = 1'b0; run(2);
    btn_raw = 1'b1; run(3);
    btn_raw = 1'b0; run(10);
    check("t3_pulses", pulse_q.size(), 0);
    check("t3_level_rises", rise_cnt, 0);

    // Tick divider, then a short disable mid-count.
    do_reset(2);
    start_test();
    run_en = 1'b1;
    run(40);
    exp_q = '{8, 16, 24, 32, 40};
    check_q("t4_tick", tick_q, exp_q);
    run(5);
    run_en = 1'b0;
    run(3);
    run_en = 1'b1;
    start_test();
    run(12);
    exp_q = '{8};
    check_q("t4_reenable_tick", tick_q, exp_q);

    // Reset while repeating with the button still held.
    run_en = 1'b0;
    do_reset(2);
    start_test();
    btn_raw = 1'b1;
    run(25);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    exp_q = '{6, 16, 21};
    check_q("t6_before_reset", pulse_q, exp_q);
    start_test();
    run(20);
    exp_q = '{6, 16};
    check_q("t6_after_reset", pulse_q, exp_q);

    // Randomized segments, including occasional resets.
    btn_raw = 1'b0;
    do_reset(2);
    for (int s = 0; s < 150; s++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) run_en = ~run_en;
      seg_len = $urandom_range(1, 40);
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
      run(seg_len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
